// File: rtl/ad9866_ctrl_pkg.sv
// Shared types, power-up register table and frame builder for the AD9866 control port.
package ad9866_ctrl_pkg;

    typedef enum logic [2:0] {
        RST_LO, RST_WAIT, INIT_LOAD, SHIFT, GAP, IDLE, LOAD
    } ctrl_state_t;

    typedef enum logic [1:0] {
        SPI_IDLE, SPI_LOAD, SPI_SHIFT, SPI_GAP
    } spi_phase_t;

    typedef enum logic {
        GRANT_HOST, GRANT_GAIN
    } grant_t;

    typedef struct packed {
        logic [5:0] addr;
        logic [7:0] data;
    } reg_write_t;

    localparam int         INIT_LEN   = 8;
    localparam logic [5:0] ADDR_RXPGA = 6'h09;

    localparam reg_write_t INIT_TABLE [INIT_LEN] = '{
        '{6'h01, 8'h00}, '{6'h02, 8'h80}, '{6'h03, 8'h00}, '{6'h04, 8'h36},
        '{6'h05, 8'h00}, '{6'h06, 8'h00}, '{6'h07, 8'h21}, '{6'h08, 8'h4B}
    };

    // Write frame: R/W bit, address, one pad bit, data; shifted MSB first.
    function automatic logic [15:0] build_frame(input logic [5:0] addr, input logic [7:0] data);
        return {1'b0, addr, 1'b0, data};
    endfunction

endpackage

// File: rtl/ad9866_spi_shift.sv
// SPI shift engine: one load cycle, 32 SCLK half-phases, then a 2*CLK_DIV gap.
module ad9866_spi_shift
    import ad9866_ctrl_pkg::*;
#(
    parameter int CLK_DIV = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [15:0] frame,
    output logic        done,
    output logic        sen_n,
    output logic        sclk,
    output logic        sdio
);

    localparam logic [8:0] HALF_LAST = 9'(CLK_DIV - 1);
    localparam logic [8:0] GAP_LAST  = 9'(2 * CLK_DIV - 1);
    localparam logic [8:0] DONE_AT   = 9'(2 * CLK_DIV - 2);

    spi_phase_t  phase, next_phase;
    logic [8:0]  cnt;
    logic [4:0]  half;
    logic [14:0] sreg;
    logic        half_end, gap_end, accept;

    assign half_end = (cnt == HALF_LAST);
    assign gap_end  = (cnt == GAP_LAST);
    // A new frame may start in the last gap cycle so init frames run back to back.
    assign accept   = start && ((phase == SPI_IDLE) || (phase == SPI_GAP && gap_end));

    always_ff @(posedge clk) begin
        if (!rst_n) phase <= SPI_IDLE;
        else        phase <= next_phase;
    end

    always_comb begin
        next_phase = phase;
        case (phase)
            SPI_IDLE:  if (accept) next_phase = SPI_LOAD;
            SPI_LOAD:  next_phase = SPI_SHIFT;
            SPI_SHIFT: if (half_end && half == 5'd31) next_phase = SPI_GAP;
            SPI_GAP:   if (gap_end) next_phase = accept ? SPI_LOAD : SPI_IDLE;
            default:   next_phase = SPI_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sen_n <= 1'b1;
            sclk  <= 1'b0;
            sdio  <= 1'b0;
            done  <= 1'b0;
            cnt   <= '0;
            half  <= '0;
            sreg  <= '0;
        end else begin
            done <= 1'b0;
            if (accept) begin
                sen_n <= 1'b0;
                sdio  <= frame[15];
                sreg  <= frame[14:0];
                cnt   <= '0;
                half  <= '0;
            end else begin
                case (phase)
                    SPI_SHIFT: begin
                        if (half_end) begin
                            cnt  <= '0;
                            half <= half + 5'd1;
                            if (!half[0]) begin
                                sclk <= 1'b1;
                            end else begin
                                sclk <= 1'b0;
                                if (half == 5'd31) begin
                                    sen_n <= 1'b1;
                                    sdio  <= 1'b0;
                                end else begin
                                    sdio <= sreg[14];
                                    sreg <= {sreg[13:0], 1'b0};
                                end
                            end
                        end else begin
                            cnt <= cnt + 9'd1;
                        end
                    end
                    SPI_GAP: begin
                        cnt  <= cnt + 9'd1;
                        done <= (cnt == DONE_AT);
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: rtl/ad9866_ctrl.sv
// AD9866 control port sequencer: reset pulse, power-up table, then host/gain arbitration.
module ad9866_ctrl
    import ad9866_ctrl_pkg::*;
#(
    parameter int CLK_DIV    = 4,
    parameter int RST_CYCLES = 64
) (
    input  logic       ad9866spiclk,
    input  logic       rst_n,
    input  logic       host_req,
    input  logic [5:0] host_addr,
    input  logic [7:0] host_data,
    output logic       host_ack,
    input  logic       gain_req,
    input  logic [5:0] gain_val,
    output logic       gain_ack,
    output logic       init_done,
    output logic       busy,
    output logic       ad9866_rst_n,
    output logic       ad9866_sen_n,
    output logic       ad9866_sclk,
    output logic       ad9866_sdio
);

    localparam int RCW   = $clog2(RST_CYCLES + 1);
    localparam int IDX_W = $clog2(INIT_LEN);
    localparam logic [RCW-1:0]   RST_LAST  = RCW'(RST_CYCLES - 1);
    localparam logic [IDX_W-1:0] INIT_LAST = IDX_W'(INIT_LEN - 1);

    ctrl_state_t      state, next_state;
    grant_t           last_grant;
    logic [RCW-1:0]   rst_cnt;
    logic [IDX_W-1:0] init_idx, init_next;
    logic [15:0]      frame;
    logic             start, done, grant_host, grant_gain, finish_init;
    logic             busy_d, rst_pin_d;

    assign init_next = init_idx + IDX_W'(1);

    ad9866_spi_shift #(.CLK_DIV(CLK_DIV)) u_shift (
        .clk   (ad9866spiclk),
        .rst_n (rst_n),
        .start (start),
        .frame (frame),
        .done  (done),
        .sen_n (ad9866_sen_n),
        .sclk  (ad9866_sclk),
        .sdio  (ad9866_sdio)
    );

    always_ff @(posedge ad9866spiclk) begin
        if (!rst_n) begin
            state        <= RST_LO;
            rst_cnt      <= '0;
            init_idx     <= '0;
            last_grant   <= GRANT_HOST;
            init_done    <= 1'b0;
            host_ack     <= 1'b0;
            gain_ack     <= 1'b0;
            busy         <= 1'b1;
            ad9866_rst_n <= 1'b0;
        end else begin
            // NOTE: sequential state is updated with non-blocking assignments only.
            state   <= next_state;
            rst_cnt <= (next_state == state && (state == RST_LO || state == RST_WAIT))
                       ? rst_cnt + RCW'(1) : '0;
            if (state == GAP && next_state == INIT_LOAD) init_idx <= init_next;
            if (grant_gain)      last_grant <= GRANT_GAIN;
            else if (grant_host) last_grant <= GRANT_HOST;
            if (finish_init) init_done <= 1'b1;
            host_ack     <= grant_host;
            gain_ack     <= grant_gain;
            busy         <= busy_d;
            ad9866_rst_n <= rst_pin_d;
        end
    end

    always_comb begin
        // NOTE: every combinational output gets a default first so no latch is inferred.
        next_state  = state;
        start       = 1'b0;
        frame       = '0;
        grant_host  = 1'b0;
        grant_gain  = 1'b0;
        finish_init = 1'b0;
        case (state)
            RST_LO:  if (rst_cnt == RST_LAST) next_state = RST_WAIT;
            RST_WAIT: if (rst_cnt == RST_LAST) begin
                next_state = INIT_LOAD;
                start      = 1'b1;
                frame      = build_frame(INIT_TABLE[0].addr, INIT_TABLE[0].data);
            end
            INIT_LOAD, LOAD: next_state = SHIFT;
            // The engine raises sen_n as its gap begins.
            SHIFT:   if (ad9866_sen_n) next_state = GAP;
            GAP: if (done) begin
                if (init_done || init_idx == INIT_LAST) begin
                    next_state  = IDLE;
                    finish_init = !init_done;
                end else begin
                    next_state = INIT_LOAD;
                    start      = 1'b1;
                    frame      = build_frame(INIT_TABLE[init_next].addr, INIT_TABLE[init_next].data);
                end
            end
            IDLE: begin
                grant_gain = gain_req && (!host_req || last_grant == GRANT_HOST);
                grant_host = host_req && !grant_gain;
                if (grant_gain) begin
                    next_state = LOAD;
                    start      = 1'b1;
                    frame      = build_frame(ADDR_RXPGA, {2'b01, gain_val});
                end else if (grant_host) begin
                    next_state = LOAD;
                    start      = 1'b1;
                    frame      = build_frame(host_addr, host_data);
                end
            end
            default: next_state = RST_LO;
        endcase
    end

    always_comb begin
        busy_d    = (next_state != IDLE);
        rst_pin_d = (next_state != RST_LO);
    end

endmodule

// File: tb/tb_ad9866_ctrl.sv
// Scoreboard bench for ad9866_ctrl: stimulus queues expected acks/frames, a monitor checks them.
`timescale 1ns/1ps
module tb_ad9866_ctrl;

    localparam int HOST = 0;
    localparam int GAIN = 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n = 1'b0, host_req = 1'b0, gain_req = 1'b0;
    logic [5:0] host_addr = '0, gain_val = '0;
    logic [7:0] host_data = '0;
    logic       host_ack, gain_ack, init_done, busy, pin_rst_n, sen_n, sclk, sdio;

    logic       r2_n = 1'b0, h2_req = 1'b0, g2_req = 1'b0;
    logic [5:0] h2_addr = '0, g2_val = '0;
    logic [7:0] h2_data = '0;
    logic       h2_ack, g2_ack, init2, busy2, pin2_rst_n, sen2_n, sclk2, sdio2;

    ad9866_ctrl #(.CLK_DIV(4), .RST_CYCLES(64)) dut (
        .ad9866spiclk(clk), .rst_n(rst_n),
        .host_req(host_req), .host_addr(host_addr), .host_data(host_data), .host_ack(host_ack),
        .gain_req(gain_req), .gain_val(gain_val), .gain_ack(gain_ack),
        .init_done(init_done), .busy(busy), .ad9866_rst_n(pin_rst_n),
        .ad9866_sen_n(sen_n), .ad9866_sclk(sclk), .ad9866_sdio(sdio)
    );

    ad9866_ctrl #(.CLK_DIV(2), .RST_CYCLES(8)) dut2 (
        .ad9866spiclk(clk), .rst_n(r2_n),
        .host_req(h2_req), .host_addr(h2_addr), .host_data(h2_data), .host_ack(h2_ack),
        .gain_req(g2_req), .gain_val(g2_val), .gain_ack(g2_ack),
        .init_done(init2), .busy(busy2), .ad9866_rst_n(pin2_rst_n),
        .ad9866_sen_n(sen2_n), .ad9866_sclk(sclk2), .ad9866_sdio(sdio2)
    );

    int checks = 0;
    int errors = 0;
    logic [15:0] exp_frames [$];
    int          exp_acks   [$];
    logic [15:0] init_words [8] = '{16'h0200, 16'h0480, 16'h0600, 16'h0836,
                                    16'h0A00, 16'h0C00, 16'h0E21, 16'h104B};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: reassemble frames on SCLK rising edges and compare acks in order.
    logic        abort_frame = 1'b0;
    logic        mon_prev_sen = 1'b1, mon_prev_sclk = 1'b0;
    logic [15:0] mon_bits = '0;
    int          mon_rises = 0, mon_low = 0, ack_early = 0;

    always @(negedge clk) begin
        if (!sen_n && mon_prev_sen) begin
            mon_bits  = '0;
            mon_rises = 0;
            mon_low   = 0;
        end
        if (sen_n === 1'b0) begin
            mon_low++;
            if (sclk && !mon_prev_sclk) begin
                mon_bits = {mon_bits[14:0], sdio};
                mon_rises++;
            end
        end else if (!mon_prev_sen && !abort_frame) begin
            if (exp_frames.size() == 0) begin
                check("frame_unexpected", exp_frames.size(), 1);
            end else begin
                check("frame_word", mon_bits, exp_frames.pop_front());
                check("frame_sclk_rises", mon_rises, 16);
                check("frame_sen_low_cycles", mon_low, 129);
            end
        end
        if (host_ack || gain_ack) begin
            if (!init_done) ack_early++;
            if (exp_acks.size() == 0) check("ack_unexpected", exp_acks.size(), 1);
            else                      check("ack_order", gain_ack ? GAIN : HOST, exp_acks.pop_front());
        end
        mon_prev_sen  = sen_n;
        mon_prev_sclk = sclk;
    end

    task automatic wait_ack(input bit is_gain, output int lat);
        logic got;
        lat = 0;
        got = 1'b0;
        while (!got && lat < 3000) begin
            @(negedge clk);
            lat++;
            got = is_gain ? gain_ack : host_ack;
        end
        if (!got) check(is_gain ? "gain_ack_timeout" : "host_ack_timeout", got, 1);
    endtask

    task automatic host_write(input logic [5:0] addr, input logic [7:0] data, output int lat);
        host_addr = addr;
        host_data = data;
        host_req  = 1'b1;
        wait_ack(1'b0, lat);
        host_req  = 1'b0;
    endtask

    task automatic gain_write(input logic [5:0] val, output int lat);
        gain_val = val;
        gain_req = 1'b1;
        wait_ack(1'b1, lat);
        gain_req = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (busy) check("idle_timeout", busy, 0);
    endtask

    // Called at a negedge with rst_n low; releases reset and times the power-up sequence.
    task automatic do_init();
        int rise_at = 0;
        int done_at = 0;
        foreach (init_words[i]) exp_frames.push_back(init_words[i]);
        rst_n = 1'b1;
        for (int k = 1; k <= 3000 && done_at == 0; k++) begin
            @(negedge clk);
            if (pin_rst_n && rise_at == 0) rise_at = k;
            if (init_done) done_at = k;
        end
        check("rst_pin_low_cycles", rise_at, 64);
        check("init_done_cycle", done_at, 1224);
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat, lat_g0, lat_h0, lat_tmp, k, low, gap, first_rise, second_rise;
        logic [15:0] word;
        logic prev;

        repeat (3) @(negedge clk);
        check("reset_rst_pin", pin_rst_n, 0);
        check("reset_sen_n", sen_n, 1);
        check("reset_sclk", sclk, 0);
        check("reset_sdio", sdio, 0);
        check("reset_acks", {host_ack, gain_ack}, 0);
        check("reset_init_done", init_done, 0);
        check("reset_busy", busy, 1);

        do_init();

        exp_acks.push_back(HOST);
        exp_frames.push_back(16'h145C);
        host_write(6'h0A, 8'h5C, lat);
        check("host_ack_latency", lat, 1);
        wait_idle();

        // Both requesters held and re-presented: grants must alternate G,H,G,H.
        exp_acks.push_back(GAIN);       exp_frames.push_back(16'h1250);
        exp_acks.push_back(HOST);       exp_frames.push_back(16'h2222);
        exp_acks.push_back(GAIN);       exp_frames.push_back(16'h1261);
        exp_acks.push_back(HOST);       exp_frames.push_back(16'h7EA5);
        fork
            begin gain_write(6'h10, lat_g0); gain_write(6'h21, lat_tmp); end
            begin host_write(6'h11, 8'h22, lat_h0); host_write(6'h3F, 8'hA5, lat); end
        join
        check("tie_gain_first_latency", lat_g0, 1);
        check("tie_host_second_latency", lat_h0, 139);
        wait_idle();

        exp_acks.push_back(GAIN);       exp_frames.push_back(16'h127F);
        exp_acks.push_back(GAIN);       exp_frames.push_back(16'h1245);
        gain_write(6'h3F, lat);
        check("gain_ack_latency", lat, 1);
        repeat (20) @(negedge clk);
        gain_write(6'h05, lat);
        check("gain_ack_after_gap", lat, 118);
        wait_idle();

        // Reset during half-phase 17 of a host frame.
        exp_acks.push_back(HOST);
        host_write(6'h0A, 8'h5C, lat);
        repeat (70) @(negedge clk);
        check("hp17_sclk_high", sclk, 1);
        check("hp17_sen_low", sen_n, 0);
        abort_frame = 1'b1;
        rst_n = 1'b0;
        @(negedge clk);
        check("midreset_sen_n", sen_n, 1);
        check("midreset_sclk", sclk, 0);
        check("midreset_sdio", sdio, 0);
        check("midreset_rst_pin", pin_rst_n, 0);
        check("midreset_init_done", init_done, 0);
        check("midreset_busy", busy, 1);

        // A request held through the whole init must wait for IDLE.
        host_addr = 6'h2A;
        host_data = 8'h3C;
        host_req  = 1'b1;
        exp_acks.push_back(HOST);
        @(negedge clk);
        abort_frame = 1'b0;
        do_init();
        exp_frames.push_back(16'h543C);
        wait_ack(1'b0, lat);
        host_req = 1'b0;
        check("held_req_ack_after_init", lat, 1);
        wait_idle();

        // CLK_DIV=2 instance with RST_CYCLES=8.
        r2_n = 1'b1;
        k = 0;
        while (!init2 && k < 3000) begin
            @(negedge clk);
            k++;
        end
        check("div2_init_done_cycle", k, 568);
        h2_addr = 6'h0A;
        h2_data = 8'h5C;
        h2_req  = 1'b1;
        k = 0;
        while (!h2_ack && k < 3000) begin
            @(negedge clk);
            k++;
        end
        h2_req = 1'b0;
        check("div2_ack_latency", k, 1);
        low = 0; gap = 0; first_rise = -1; second_rise = -1; word = '0; prev = 1'b0;
        for (int idx = 0; idx < 300; idx++) begin
            if (!sen2_n) begin
                low++;
                if (sclk2 && !prev) begin
                    word = {word[14:0], sdio2};
                    if (first_rise < 0)       first_rise  = idx;
                    else if (second_rise < 0) second_rise = idx;
                end
            end else if (busy2) begin
                gap++;
            end else begin
                break;
            end
            prev = sclk2;
            @(negedge clk);
        end
        check("div2_frame_word", word, 16'h145C);
        check("div2_sclk_period", second_rise - first_rise, 4);
        check("div2_sen_low_cycles", low, 65);
        check("div2_gap_cycles", gap, 4);
        check("div2_frame_cost", low + gap, 69);

        check("frames_left", exp_frames.size(), 0);
        check("acks_left", exp_acks.size(), 0);
        check("acks_before_init", ack_early, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
